// File: rtl/binary_frame_reader.sv
// rtl/binary_frame_reader.sv - expands a double-buffered 1bpp frame into RGB pixels
// Word fetch at each 32-pixel boundary, 2-cycle latency from raster counters to pixel.
module binary_frame_reader #(
  parameter int          IMG_WIDTH  = 320,
  parameter int          IMG_HEIGHT = 240,
  parameter int          ADDR_W     = 13,
  parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [11:0]       h_cnt,
  input  logic [10:0]       v_cnt,
  input  logic              frame_ready,
  output logic              frame_ack,
  output logic              rd_bank,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_dout,
  output logic [23:0]       binary,
  output logic              pix_valid
);

  localparam int WPR   = IMG_WIDTH / 32;
  localparam int IDX_W = ADDR_W - 1;

  typedef enum logic {S_EMPTY, S_SHOW} state_t;

  state_t r_state, w_state_nxt;
  logic   r_pending, w_pending_nxt;
  logic   r_rd_bank, w_rd_bank_nxt;
  logic   r_frame_ack, w_frame_ack_nxt;

  logic             w_in_img, w_swap_pt, w_show;
  logic [IDX_W-1:0] w_word_idx;

  logic        r_en_d1, r_vld_d1;
  logic [4:0]  r_bit_sel_d1;
  logic [31:0] r_word;
  logic [23:0] r_binary;
  logic        r_pix_valid;
  logic [31:0] w_word_cur;
  logic        w_bit;

  assign w_in_img  = (h_cnt < 12'(IMG_WIDTH)) && (v_cnt < 11'(IMG_HEIGHT));
  assign w_swap_pt = (v_cnt == 11'(IMG_HEIGHT)) && (h_cnt == 12'd0);
  assign w_show    = (r_state == S_SHOW);

  // Only in-image coordinates are meaningful; elsewhere the index is parked at 0.
  assign w_word_idx = w_in_img ? (IDX_W'(v_cnt) * IDX_W'(WPR) + IDX_W'(h_cnt[11:5]))
                               : {IDX_W{1'b0}};

  always_comb begin
    w_state_nxt     = r_state;
    w_pending_nxt   = r_pending;
    w_rd_bank_nxt   = r_rd_bank;
    w_frame_ack_nxt = 1'b0;
    if (w_swap_pt && (r_pending || frame_ready)) begin
      w_rd_bank_nxt   = ~r_rd_bank;
      w_pending_nxt   = 1'b0;
      w_frame_ack_nxt = 1'b1;
      w_state_nxt     = S_SHOW;
    end else if (frame_ready) begin
      w_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_pending   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_frame_ack <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_frame_ack <= w_frame_ack_nxt;
    end
  end

  assign mem_en   = w_in_img && w_show && (h_cnt[4:0] == 5'd0);
  assign mem_addr = {r_rd_bank, w_word_idx};

  // On the fetch cycle the RAM output bypasses the word register.
  assign w_word_cur = r_en_d1 ? mem_dout : r_word;
  assign w_bit      = w_word_cur[r_bit_sel_d1];

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_en_d1      <= 1'b0;
      r_vld_d1     <= 1'b0;
      r_bit_sel_d1 <= 5'd0;
      r_word       <= 32'd0;
      r_binary     <= 24'd0;
      r_pix_valid  <= 1'b0;
    end else begin
      r_en_d1      <= mem_en;
      r_vld_d1     <= w_in_img && w_show;
      r_bit_sel_d1 <= h_cnt[4:0];
      if (r_en_d1) begin
        r_word <= mem_dout;
      end
      r_binary    <= r_vld_d1 ? (w_bit ? FG_COLOR : BG_COLOR) : 24'd0;
      r_pix_valid <= r_vld_d1;
    end
  end

  assign frame_ack = r_frame_ack;
  assign rd_bank   = r_rd_bank;
  assign binary    = r_binary;
  assign pix_valid = r_pix_valid;

endmodule

// File: doc/binary_frame_reader.md
Name: binary_frame_reader

Overview:
- Reads back a 1-bit-per-pixel binarized frame from a double-buffered frame memory.
- Expands each stored bit to a 24-bit RGB pixel in step with the display raster counters (h_cnt/v_cnt).
- Sits on the read side of the binary frame buffer: the binarization/writer path fills one bank while this block displays the other.
- Bank swaps are negotiated with a frame_ready/frame_ack handshake.

Parameters:
- IMG_WIDTH, 320: image width in pixels; must be a multiple of 32.
- IMG_HEIGHT, 240: image height in lines.
- ADDR_W, 13: memory address width = 1 bank bit + word-index bits; the word index must cover IMG_WIDTH*IMG_HEIGHT/32 words.
- FG_COLOR, 24'hFFFFFF: RGB output for a stored 1.
- BG_COLOR, 24'h000000: RGB output for a stored 0 inside the image.

Ports:
- pclk  in  1  pixel clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- h_cnt  in  12  raster horizontal position.
- v_cnt  in  11  raster vertical position.
- frame_ready  in  1  one-cycle pulse: the writer has completed a frame in the bank != rd_bank.
- frame_ack  out  1  one-cycle pulse when the bank swap occurs.
- rd_bank  out  1  bank currently displayed; the writer uses the other bank.
- mem_en  out  1  memory read enable.
- mem_addr  out  ADDR_W  {rd_bank, word_index}.
- mem_dout  in  32  read data; synchronous RAM, valid 1 cycle after mem_en.
- binary  out  24  output pixel.
- pix_valid  out  1  binary carries an in-image pixel.

Behaviour:
- Reset (rst_n=0 at an edge) sets:
  - state=EMPTY, rd_bank=0, pending=0, frame_ack=0;
  - binary=0, pix_valid=0, word register=0, pipeline valid bits=0.
  - mem_en is 0 while in EMPTY.
  - Reset mid-frame discards any pending swap.
- Memory layout:
  - WPR = IMG_WIDTH/32 words per row.
  - Pixel (h,v) is bit h[4:0] of word v*WPR + h/32, LSB = leftmost pixel.
- Image region: in_img = (h_cnt < IMG_WIDTH) && (v_cnt < IMG_HEIGHT).
- Fetch (combinational, cycle T):
  - mem_en = in_img && state==SHOW && h_cnt[4:0]==0.
  - mem_addr = {rd_bank, v_cnt*WPR + h_cnt[11:5]}.
- Pipeline:
  - Cycle T+1, load case: if the delayed mem_en is 1, the word register loads mem_dout and the pixel bit is taken from mem_dout directly.
  - Cycle T+1, other pixels: the bit comes from the word register, indexed by h_cnt[4:0] delayed 1 cycle.
  - Cycle T+2: binary is registered as FG_COLOR if the bit is 1, else BG_COLOR. pix_valid = in_img && SHOW, delayed 2 cycles.
  - Latency from h_cnt/v_cnt to binary/pix_valid is exactly 2 cycles.
- Outside the image, or in EMPTY: binary=24'h0, pix_valid=0 (BG_COLOR is not used there).
- State machine:
  - EMPTY: no valid frame has been displayed yet.
  - SHOW: a frame is being displayed.
  - Swap point: the cycle with v_cnt==IMG_HEIGHT && h_cnt==0 (first blanking line).
  - At the swap point with pending=1, or frame_ready=1 in that same cycle: rd_bank toggles, pending clears, frame_ack pulses for one cycle, and state becomes SHOW.
  - Otherwise the state holds.
- Handshake:
  - frame_ready sets pending.
  - frame_ready while pending is already 1 is absorbed: only one swap and one ack result.
  - The writer must not write the bank it just released until it sees frame_ack.
  - frame_ready and reset in the same cycle: reset wins.
- No memory access ever occurs outside the image region. The word index never exceeds IMG_HEIGHT*WPR-1.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles mid-line at (h=50,v=20) -> next cycle binary=0, pix_valid=0, rd_bank=0, frame_ack=0; mem_en stays 0 for the rest of the frame.
- Run a full frame in EMPTY with no frame_ready -> mem_en never 1, pix_valid never 1, binary constant 0.
- Pulse frame_ready at (h=10,v=100) -> at (h=0,v=240) rd_bank 0->1 and frame_ack=1 for exactly one cycle. Next frame: mem_en at h=0,32,...,288 of every line; at (h=0,v=1) mem_addr={1,12'd10}.
- Memory model word 0 = 32'h0000_0005 in bank 1 -> binary for (0,0)=FFFFFF, (1,0)=000000, (2,0)=FFFFFF, each appearing 2 cycles after the corresponding h_cnt, with pix_valid=1.
- Assert frame_ready exactly on the swap cycle, plus a second frame_ready 5 cycles before it -> one toggle and one frame_ack pulse only.
- Boundaries:
  - (h=319,v=239) outputs bit 31 of word 2399.
  - (h=320,v=0) and (h=0,v=240) give pix_valid=0, binary=0, and no mem_en.
